// File: rtl/alu_rr_sharer.sv
// Round-robin sharer of one external combinational ALU between two requesters.
// Each accepted operation runs IDLE -> EXEC -> RESP with no overlap between operations.
module alu_rr_sharer #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [1:0]       req_cmd0,
  input  logic [1:0]       req_cmd1,
  input  logic [WIDTH-1:0] req_a0,
  input  logic [WIDTH-1:0] req_a1,
  input  logic [WIDTH-1:0] req_b0,
  input  logic [WIDTH-1:0] req_b1,
  output logic [1:0]       rsp_valid,
  input  logic [1:0]       rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic [1:0]       alu_cmd,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_out,
  output logic             busy,
  output logic [CNT_W-1:0] done_cnt0,
  output logic [CNT_W-1:0] done_cnt1
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state;
  logic   gnt;
  logic   last_grant;
  logic   win_c;
  logic   win_vld_c;

  // Arbitration: a lone requester wins; on a tie the one not granted last time wins.
  always_comb begin
    win_c     = 1'b0;
    win_vld_c = 1'b0;
    if (rst_n && state == IDLE) begin
      case (req_valid)
        2'b01: begin win_c = 1'b0;        win_vld_c = 1'b1; end
        2'b10: begin win_c = 1'b1;        win_vld_c = 1'b1; end
        2'b11: begin win_c = ~last_grant; win_vld_c = 1'b1; end
        default: begin win_c = 1'b0;      win_vld_c = 1'b0; end
      endcase
    end
  end

  assign req_ready = {win_vld_c & win_c, win_vld_c & ~win_c};

  // The alu_* outputs double as the operand registers, so they hold between operations.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      gnt        <= 1'b0;
      last_grant <= 1'b1;
      rsp_valid  <= 2'b00;
      rsp_data   <= '0;
      alu_cmd    <= 2'b00;
      alu_a      <= '0;
      alu_b      <= '0;
      busy       <= 1'b0;
      done_cnt0  <= '0;
      done_cnt1  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (win_vld_c) begin
            alu_cmd    <= win_c ? req_cmd1 : req_cmd0;
            alu_a      <= win_c ? req_a1   : req_a0;
            alu_b      <= win_c ? req_b1   : req_b0;
            gnt        <= win_c;
            last_grant <= win_c;
            busy       <= 1'b1;
            state      <= EXEC;
          end
        end
        EXEC: begin
          rsp_data  <= alu_out;
          rsp_valid <= {gnt, ~gnt};
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready[gnt]) begin
            rsp_valid <= 2'b00;
            busy      <= 1'b0;
            state     <= IDLE;
            if (gnt) begin
              if (done_cnt1 != CNT_MAX) done_cnt1 <= done_cnt1 + CNT_W'(1);
            end else begin
              if (done_cnt0 != CNT_MAX) done_cnt0 <= done_cnt0 + CNT_W'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_rr_sharer.sv
// Bench for alu_rr_sharer: transaction-level reference model compared every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_alu_rr_sharer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] req_valid, req_ready;
  logic [1:0] req_cmd0, req_cmd1;
  logic [3:0] req_a0, req_a1, req_b0, req_b1;
  logic [1:0] rsp_valid, rsp_ready;
  logic [3:0] rsp_data;
  logic [1:0] alu_cmd;
  logic [3:0] alu_a, alu_b, alu_out;
  logic       busy;
  logic [7:0] done_cnt0, done_cnt1;

  int n_checks = 0;
  int n_err    = 0;
  bit chk_en   = 1'b0;

  alu_rr_sharer #(.WIDTH(4), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_cmd0(req_cmd0), .req_cmd1(req_cmd1),
    .req_a0(req_a0), .req_a1(req_a1), .req_b0(req_b0), .req_b1(req_b1),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .alu_cmd(alu_cmd), .alu_a(alu_a), .alu_b(alu_b), .alu_out(alu_out),
    .busy(busy), .done_cnt0(done_cnt0), .done_cnt1(done_cnt1)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] alu_f(input logic [1:0] c, input logic [3:0] a, input logic [3:0] b);
    case (c)
      2'b00:   return a & b;
      2'b01:   return a | b;
      2'b10:   return 4'(a + b);
      default: return 4'(a - b);
    endcase
  endfunction

  // External ALU instance
  always_comb alu_out = alu_f(alu_cmd, alu_a, alu_b);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: m_owner is the requester whose op is in flight (-1 none),
  // m_age counts edges since acceptance (1 = executing, 2 = responding).
  int         m_owner, m_age, m_last;
  int         m_cnt [2];
  logic [1:0] m_cmd;
  logic [3:0] m_a, m_b, m_res, m_data;

  function automatic int exp_win();
    if (!rst_n || m_owner >= 0) return -1;
    case (req_valid)
      2'b01:   return 0;
      2'b10:   return 1;
      2'b11:   return 1 - m_last;
      default: return -1;
    endcase
  endfunction

  always @(posedge clk) begin
    int w;
    if (!rst_n) begin
      m_owner = -1; m_age = 0; m_last = 1;
      m_cmd = 2'b00; m_a = 4'h0; m_b = 4'h0; m_res = 4'h0; m_data = 4'h0;
      m_cnt[0] = 0; m_cnt[1] = 0;
    end else if (m_owner < 0) begin
      w = exp_win();
      if (w >= 0) begin
        m_owner = w; m_age = 1; m_last = w;
        if (w == 0) begin m_cmd = req_cmd0; m_a = req_a0; m_b = req_b0; end
        else        begin m_cmd = req_cmd1; m_a = req_a1; m_b = req_b1; end
        m_res = alu_f(m_cmd, m_a, m_b);
      end
    end else if (m_age < 2) begin
      m_age  = 2;
      m_data = m_res;
    end else if (rsp_ready[m_owner]) begin
      if (m_cnt[m_owner] < 255) m_cnt[m_owner] = m_cnt[m_owner] + 1;
      m_owner = -1;
    end
  end

  always @(negedge clk) begin
    int w;
    logic [1:0] er, ev;
    if (chk_en) begin
      w  = exp_win();
      er = (w < 0) ? 2'b00 : ((w == 0) ? 2'b01 : 2'b10);
      ev = (m_owner >= 0 && m_age == 2) ? ((m_owner == 0) ? 2'b01 : 2'b10) : 2'b00;
      check("req_ready", 32'(req_ready), 32'(er));
      check("rsp_valid", 32'(rsp_valid), 32'(ev));
      check("busy",      32'(busy),      32'(m_owner >= 0));
      check("rsp_data",  32'(rsp_data),  32'(m_data));
      check("alu_cmd",   32'(alu_cmd),   32'(m_cmd));
      check("alu_a",     32'(alu_a),     32'(m_a));
      check("alu_b",     32'(alu_b),     32'(m_b));
      check("done_cnt0", 32'(done_cnt0), 32'(m_cnt[0]));
      check("done_cnt1", 32'(done_cnt1), 32'(m_cnt[1]));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One operation from requester i; d>0 stalls the response d cycles while the
  // other requester asserts valid and its own rsp_ready.
  task automatic do_op(input int i, input logic [1:0] c, input logic [3:0] a, input logic [3:0] b,
                       input int d, output logic [3:0] data, output int lat);
    int o;
    bit got;
    o = 1 - i;
    if (i == 0) begin req_cmd0 = c; req_a0 = a; req_b0 = b; end
    else        begin req_cmd1 = c; req_a1 = a; req_b1 = b; end
    req_valid[i] = 1'b1;
    if (d == 0) rsp_ready[i] = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (req_ready[i]) begin got = 1'b1; break; end
    end
    check("grant_wait", 32'(got), 32'd1);
    tick();
    req_valid[i] = 1'b0;
    lat = 0; got = 1'b0; data = 4'h0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      lat++;
      if (rsp_valid[i]) begin got = 1'b1; data = rsp_data; break; end
    end
    check("rsp_wait", 32'(got), 32'd1);
    if (d > 0) begin
      repeat (d) begin
        tick();
        req_valid[o] = 1'b1;
        rsp_ready[o] = 1'b1;
        @(negedge clk);
        check("stall_req_ready", 32'(req_ready), 32'd0);
        check("stall_busy",      32'(busy),      32'd1);
        check("stall_data",      32'(rsp_data),  32'(data));
      end
      rsp_ready[i] = 1'b1;
    end
    tick();
    rsp_ready    = 2'b00;
    req_valid[o] = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] data;
    int lat;
    int grants[$];
    bit got;

    rst_n = 1'b0;
    req_cmd0 = 2'b10; req_a0 = 4'h1; req_b0 = 4'h2;
    req_cmd1 = 2'b11; req_a1 = 4'h1; req_b1 = 4'h2;
    req_valid = 2'b11;
    rsp_ready = 2'b11;

    // Reset values while both requesters are already valid
    tick();
    @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_busy",      32'(busy),      32'd0);
    check("rst_rsp_data",  32'(rsp_data),  32'd0);
    check("rst_done_cnt0", 32'(done_cnt0), 32'd0);
    check("rst_alu_a",     32'(alu_a),     32'd0);
    tick();
    rst_n  = 1'b1;
    chk_en = 1'b1;

    // Both valid continuously from reset: grants alternate 0,1,0,1
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (req_ready != 2'b00) grants.push_back((req_ready == 2'b10) ? 1 : 0);
      if (grants.size() == 4) break;
    end
    tick();
    req_valid = 2'b00;
    repeat (4) tick();
    rsp_ready = 2'b00;
    check("rr_count", 32'(grants.size()), 32'd4);
    if (grants.size() == 4) begin
      check("rr_g0", 32'(grants[0]), 32'd0);
      check("rr_g1", 32'(grants[1]), 32'd1);
      check("rr_g2", 32'(grants[2]), 32'd0);
      check("rr_g3", 32'(grants[3]), 32'd1);
    end
    check("rr_cnt0", 32'(done_cnt0), 32'd2);
    check("rr_cnt1", 32'(done_cnt1), 32'd2);

    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;

    // Req0 only: 9 + 8 = 17 -> 1
    do_op(0, 2'b10, 4'h9, 4'h8, 0, data, lat);
    check("t1_data",  32'(data),      32'h1);
    check("t1_lat",   32'(lat),       32'd2);
    check("t1_cnt0",  32'(done_cnt0), 32'd1);

    // Req1 only: SUB, AND, OR
    do_op(1, 2'b11, 4'h3, 4'h5, 0, data, lat);
    check("t2_sub", 32'(data), 32'hE);
    do_op(1, 2'b00, 4'hC, 4'hA, 0, data, lat);
    check("t2_and", 32'(data), 32'h8);
    do_op(1, 2'b01, 4'hC, 4'hA, 0, data, lat);
    check("t2_or",  32'(data), 32'hE);
    check("t2_cnt1", 32'(done_cnt1), 32'd3);

    // Backpressure: F & 6 = 6, held 5 cycles
    do_op(0, 2'b00, 4'hF, 4'h6, 5, data, lat);
    check("t4_data", 32'(data),      32'h6);
    check("t4_cnt0", 32'(done_cnt0), 32'd2);
    check("t4_cnt1", 32'(done_cnt1), 32'd3);

    // Reset during EXEC discards the op; the next tie goes to requester 0
    req_cmd0 = 2'b10; req_a0 = 4'h5; req_b0 = 4'h5;
    req_valid = 2'b01;
    got = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (req_ready[0]) begin got = 1'b1; break; end
    end
    check("t5_grant", 32'(got), 32'd1);
    tick();
    req_valid = 2'b00;
    @(negedge clk);
    check("t5_exec_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    tick();
    rst_n     = 1'b1;
    rsp_ready = 2'b11;
    req_valid = 2'b11;
    @(negedge clk);
    check("t5_rsp_valid", 32'(rsp_valid), 32'd0);
    check("t5_busy",      32'(busy),      32'd0);
    check("t5_rsp_data",  32'(rsp_data),  32'd0);
    check("t5_cnt0",      32'(done_cnt0), 32'd0);
    check("t5_cnt1",      32'(done_cnt1), 32'd0);
    check("t5_alu_cmd",   32'(alu_cmd),   32'd0);
    check("t5_tie",       32'(req_ready), 32'b01);
    tick();
    req_valid = 2'b00;
    repeat (3) tick();
    rsp_ready = 2'b00;
    check("t5_after_cnt0", 32'(done_cnt0), 32'd1);

    // Saturation: 254 more ops reach 8'hFF, one more stays there
    repeat (254) do_op(0, 2'b10, 4'h1, 4'h1, 0, data, lat);
    check("t6_at_max", 32'(done_cnt0), 32'hFF);
    do_op(0, 2'b10, 4'h7, 4'h9, 0, data, lat);
    check("t6_sat",      32'(done_cnt0), 32'hFF);
    check("t6_wrap_add", 32'(data),      32'h0);

    repeat (2) tick();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
